// File: rtl/itch_pkg.sv
// rtl/itch_pkg.sv - shared framer states, ITCH message-type codes and expected-length lookup
package itch_pkg;

   typedef enum logic [1:0] {
      LEN_HI,
      LEN_LO,
      PAYLOAD,
      DROP
   } framer_state_t;

   localparam logic [7:0] TYPE_S = 8'h53;
   localparam logic [7:0] TYPE_R = 8'h52;
   localparam logic [7:0] TYPE_H = 8'h48;
   localparam logic [7:0] TYPE_A = 8'h41;
   localparam logic [7:0] TYPE_F = 8'h46;
   localparam logic [7:0] TYPE_E = 8'h45;
   localparam logic [7:0] TYPE_C = 8'h43;
   localparam logic [7:0] TYPE_X = 8'h58;
   localparam logic [7:0] TYPE_D = 8'h44;
   localparam logic [7:0] TYPE_U = 8'h55;
   localparam logic [7:0] TYPE_P = 8'h50;
   localparam logic [7:0] TYPE_Q = 8'h51;
   localparam logic [7:0] TYPE_B = 8'h42;

   // Zero means the type is not one we know a fixed length for.
   function automatic logic [15:0] expected_len(input logic [7:0] msg_type);
      case (msg_type)
         TYPE_S:  expected_len = 16'd12;
         TYPE_R:  expected_len = 16'd39;
         TYPE_H:  expected_len = 16'd25;
         TYPE_A:  expected_len = 16'd36;
         TYPE_F:  expected_len = 16'd40;
         TYPE_E:  expected_len = 16'd31;
         TYPE_C:  expected_len = 16'd36;
         TYPE_X:  expected_len = 16'd23;
         TYPE_D:  expected_len = 16'd19;
         TYPE_U:  expected_len = 16'd35;
         TYPE_P:  expected_len = 16'd44;
         TYPE_Q:  expected_len = 16'd40;
         TYPE_B:  expected_len = 16'd19;
         default: expected_len = 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/itch_len_lut.sv
// rtl/itch_len_lut.sv - combinational message type to expected payload length, with known flag
module itch_len_lut
   import itch_pkg::*;
(
   input  logic [7:0]  msg_type,
   output logic [15:0] exp_len,
   output logic        known
);

   always_comb begin
      exp_len = expected_len(msg_type);
      known   = (exp_len != 16'd0);
   end

endmodule

// File: rtl/itch_framer.sv
// rtl/itch_framer.sv - length-prefixed byte stream to start/end framed payload beats with drop stats
// Type/length consistency check is built only when ITCH_TYPE_CHECK_EN is defined.
module itch_framer
   import itch_pkg::*;
#(
   parameter int unsigned MAX_LEN = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic [7:0]  message,
   output logic        valid,
   output logic        start_msg,
   output logic        end_msg,
   output logic        frame_active,
   output logic        err_len,
   output logic        err_type,
   output logic [31:0] msg_count,
   output logic [15:0] drop_count
);

   framer_state_t state;
   logic [7:0]    len_hi;
   logic [15:0]   remaining;
   logic          first;
   logic [15:0]   len_full;

   assign len_full = {len_hi, in_data};

`ifdef ITCH_TYPE_CHECK_EN
   logic [15:0] lut_len;
   logic        lut_known;

   itch_len_lut u_len_lut (
      .msg_type (in_data),
      .exp_len  (lut_len),
      .known    (lut_known)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LEN_HI;
         len_hi       <= 8'd0;
         remaining    <= 16'd0;
         first        <= 1'b0;
         message      <= 8'd0;
         valid        <= 1'b0;
         start_msg    <= 1'b0;
         end_msg      <= 1'b0;
         frame_active <= 1'b0;
         err_len      <= 1'b0;
         err_type     <= 1'b0;
         msg_count    <= 32'd0;
         drop_count   <= 16'd0;
      end else begin
         valid     <= 1'b0;
         start_msg <= 1'b0;
         end_msg   <= 1'b0;
         err_len   <= 1'b0;
         err_type  <= 1'b0;
         if (in_valid) begin
            case (state)
               LEN_HI: begin
                  len_hi <= in_data;
                  state  <= LEN_LO;
               end
               LEN_LO: begin
                  // A zero length is a heartbeat: nothing is forwarded or counted.
                  if (len_full == 16'd0) begin
                     state <= LEN_HI;
                  end else if (32'(len_full) > MAX_LEN) begin
                     state        <= DROP;
                     remaining    <= len_full;
                     frame_active <= 1'b1;
                     err_len      <= 1'b1;
                     if (drop_count != 16'hFFFF)
                        drop_count <= drop_count + 16'd1;
                  end else begin
                     state        <= PAYLOAD;
                     remaining    <= len_full;
                     first        <= 1'b1;
                     frame_active <= 1'b1;
                  end
               end
               PAYLOAD: begin
                  message   <= in_data;
                  valid     <= 1'b1;
                  start_msg <= first;
                  first     <= 1'b0;
`ifdef ITCH_TYPE_CHECK_EN
                  // On the first byte remaining still holds the full frame length.
                  if (first && lut_known && (lut_len != remaining))
                     err_type <= 1'b1;
`endif
                  if (remaining == 16'd1) begin
                     end_msg      <= 1'b1;
                     msg_count    <= msg_count + 32'd1;
                     state        <= LEN_HI;
                     frame_active <= 1'b0;
                  end else begin
                     remaining <= remaining - 16'd1;
                  end
               end
               DROP: begin
                  if (remaining == 16'd1) begin
                     state        <= LEN_HI;
                     frame_active <= 1'b0;
                  end else begin
                     remaining <= remaining - 16'd1;
                  end
               end
               default: begin
                  state        <= LEN_HI;
                  frame_active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
